// File: rtl/uart_tx_image_pkg.sv
// Shared definitions for the image transmitter: frame/sequencer state
// encodings and default frame geometry (also used by the receive path).
package uart_tx_image_pkg;

  localparam int DATA_TICKS_DEF = 16;  // oversample ticks per bit period
  localparam int BITS_DEF       = 8;   // data bits per frame
  localparam int TICK_CNT_W     = 5;   // tick counter width, counts 1..DATA_TICKS

  // Serial frame phases of the byte engine
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } frame_state_t;

  // Image sequencer phases
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_LOAD  = 2'b10,
    S_WAIT  = 2'b11
  } seq_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// Byte engine: serialises one byte as 8N1, LSB first. Bit timing is counted
// in baud ticks only, so holding ticks low freezes the whole frame.
module uart_tx_byte
  import uart_tx_image_pkg::*;
#(
  parameter int DATA_TICKS = DATA_TICKS_DEF,
  parameter int BITS       = BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ticks,
  input  logic       load,
  input  logic [7:0] din,
  output logic       Tx,
  output logic       ready,
  output logic       Tx_done
);

  localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [TICK_CNT_W-1:0] CNT_LAST = TICK_CNT_W'(DATA_TICKS);
  localparam logic [TICK_CNT_W-1:0] CNT_ONE  = TICK_CNT_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(BITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);

  frame_state_t          state_reg, state_next;
  logic [TICK_CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [IDX_W-1:0]      idx_inc;
  logic [7:0]            data_reg, data_next;
  logic                  tx_reg, tx_next;
  logic                  done_reg, done_next;

  // Frame state, counters and the registered line/pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
    end
  end

  assign idx_inc = idx_reg + IDX_ONE;

  // Next-state: each phase lasts DATA_TICKS ticks; the counter restarts at 1
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    tx_next    = tx_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (load) begin
          data_next  = din;
          tx_next    = 1'b0;
          cnt_next   = CNT_ONE;
          state_next = START;
        end
      end
      START: begin
        if (ticks) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = CNT_ONE;
            idx_next   = '0;
            tx_next    = data_reg[0];
            state_next = DATA;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end
      DATA: begin
        if (ticks) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next = CNT_ONE;
            if (idx_reg == IDX_LAST) begin
              tx_next    = 1'b1;
              state_next = STOP;
            end else begin
              idx_next = idx_inc;
              tx_next  = data_reg[idx_inc];
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end
      STOP: begin
        if (ticks) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Tx      = tx_reg;
  assign Tx_done = done_reg;
  assign ready   = (state_reg == IDLE);

endmodule

// File: rtl/uart_tx_image.sv
// Image transmitter: walks the image BRAM from address 0 to NUM_BYTES-1 and
// hands each byte to the byte engine, pulsing img_done after the last one.
module uart_tx_image
  import uart_tx_image_pkg::*;
#(
  parameter int DATA_TICKS = DATA_TICKS_DEF,
  parameter int BITS       = BITS_DEF,
  parameter int NUM_BYTES  = 784,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ticks,
  input  logic              start,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [7:0]        data_ram,
  output logic              Tx,
  output logic              busy,
  output logic              Tx_done,
  output logic              img_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  seq_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              busy_reg, busy_next;
  logic              byte_load;
  logic              byte_ready;
  logic              byte_done;

  uart_tx_byte #(
    .DATA_TICKS (DATA_TICKS),
    .BITS       (BITS)
  ) u_tx_byte (
    .clk     (clk),
    .rst     (rst),
    .ticks   (ticks),
    .load    (byte_load),
    .din     (data_ram),
    .Tx      (Tx),
    .ready   (byte_ready),
    .Tx_done (byte_done)
  );

  // Sequencer state, read address and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      busy_reg  <= busy_next;
    end
  end

  // Next-state: fetch, load, wait for the byte to finish, then advance or wrap
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    busy_next  = busy_reg;
    byte_load  = 1'b0;
    img_done   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          busy_next  = 1'b1;
          addr_next  = '0;
          state_next = S_FETCH;
        end
      end
      // BRAM data for addr_reg appears one clk after the address settles
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        if (byte_ready) begin
          byte_load  = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (byte_done) begin
          if (addr_reg == LAST_ADDR) begin
            img_done   = 1'b1;
            busy_next  = 1'b0;
            addr_next  = '0;
            state_next = S_IDLE;
          end else begin
            addr_next  = addr_reg + ADDR_ONE;
            state_next = S_FETCH;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign addr_b  = addr_reg;
  assign busy    = busy_reg;
  assign Tx_done = byte_done;

endmodule

// File: tb/tb_uart_tx_image.sv
// Directed bench: instance A sends a one-byte image (0xA5) at 16 ticks/bit
// with a tick every third clk; instance B sends the full 784-byte image at
// 2 ticks/bit with ticks held high. Tick-driven decoders rebuild the bytes.
module tb_uart_tx_image;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // Instance A: single-byte image
  logic       rst_a, ticks_a, start_a, tx_a, busy_a, txd_a, img_a;
  logic [9:0] addr_a;
  logic [7:0] ram_a;
  logic       tick_en_a;

  // Instance B: full image, short bit period
  logic       rst_b, ticks_b, start_b, tx_b, busy_b, txd_b, img_b;
  logic [9:0] addr_b;
  logic [7:0] ram_b;

  uart_tx_image #(.DATA_TICKS(16), .BITS(8), .NUM_BYTES(1), .ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst_a), .ticks(ticks_a), .start(start_a), .addr_b(addr_a),
    .data_ram(ram_a), .Tx(tx_a), .busy(busy_a), .Tx_done(txd_a), .img_done(img_a)
  );

  uart_tx_image #(.DATA_TICKS(2), .BITS(8), .NUM_BYTES(784), .ADDR_W(10)) dut_b (
    .clk(clk), .rst(rst_b), .ticks(ticks_b), .start(start_b), .addr_b(addr_b),
    .data_ram(ram_b), .Tx(tx_b), .busy(busy_b), .Tx_done(txd_b), .img_done(img_b)
  );

  // BRAM read ports, one clk latency
  always @(posedge clk) ram_a <= (addr_a == 10'd0) ? 8'hA5 : 8'h00;
  always @(posedge clk) ram_b <= addr_b[7:0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tick generator for A: one tick every third clk while enabled
  initial begin
    int div;
    div = 0;
    ticks_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tick_en_a) begin
        div = (div == 2) ? 0 : div + 1;
        ticks_a = (div == 0);
      end else begin
        ticks_a = 1'b0;
      end
    end
  end

  // Decoder state: tick sample count, slot errors, Tx_done alignment, pulses
  bit         act_a = 0, act_b = 0, exp_done_a = 0, exp_done_b = 0;
  int         n_a = 0, n_b = 0;
  int         slot_err_a = 0, slot_err_b = 0, align_err_a = 0, align_err_b = 0;
  int         done_cnt_a = 0, img_cnt_a = 0, coinc_err_a = 0;
  int         img_cnt_b = 0, coinc_err_b = 0;
  logic [7:0] byte_a, byte_b;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  // Decoder A: each sample is the line value before a ticking edge
  initial begin
    int slot, pos;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        act_a = 0; exp_done_a = 0;
      end else begin
        if (txd_a) done_cnt_a++;
        if (img_a) img_cnt_a++;
        if (img_a && !txd_a) coinc_err_a++;
        if (exp_done_a != txd_a) align_err_a++;
        exp_done_a = 0;
        if (!act_a && tx_a === 1'b0) begin act_a = 1; n_a = 0; end
        if (act_a && ticks_a) begin
          n_a++;
          slot = (n_a - 1) / 16;
          pos  = (n_a - 1) % 16;
          if (slot == 0) begin if (tx_a !== 1'b0) slot_err_a++; end
          else if (slot == 9) begin if (tx_a !== 1'b1) slot_err_a++; end
          else if (pos == 0) byte_a[slot-1] = tx_a;
          else if (byte_a[slot-1] !== tx_a) slot_err_a++;
          if (n_a == 160) begin q_a.push_back(byte_a); act_a = 0; exp_done_a = 1; end
        end
      end
    end
  end

  // Decoder B: same scheme, 2 ticks per bit
  initial begin
    int slot, pos;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        act_b = 0; exp_done_b = 0;
      end else begin
        if (img_b) img_cnt_b++;
        if (img_b && !txd_b) coinc_err_b++;
        if (exp_done_b != txd_b) align_err_b++;
        exp_done_b = 0;
        if (!act_b && tx_b === 1'b0) begin act_b = 1; n_b = 0; end
        if (act_b && ticks_b) begin
          n_b++;
          slot = (n_b - 1) / 2;
          pos  = (n_b - 1) % 2;
          if (slot == 0) begin if (tx_b !== 1'b0) slot_err_b++; end
          else if (slot == 9) begin if (tx_b !== 1'b1) slot_err_b++; end
          else if (pos == 0) byte_b[slot-1] = tx_b;
          else if (byte_b[slot-1] !== tx_b) slot_err_b++;
          if (n_b == 20) begin q_b.push_back(byte_b); act_b = 0; exp_done_b = 1; end
        end
      end
    end
  end

  function automatic logic [7:0] last_a();
    if (q_a.size() == 0) return 8'hxx;
    return q_a[q_a.size()-1];
  endfunction

  function automatic logic [7:0] qb_at(input int i);
    if (i >= q_b.size()) return 8'hxx;
    return q_b[i];
  endfunction

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_img_a(input int lim, input string tag);
    for (int i = 0; i < lim && img_a !== 1'b1; i++) @(negedge clk);
    check_eq(tag, 32'(img_a), 32'd1);
  endtask

  task automatic wait_n_a(input int target, input int lim);
    for (int i = 0; i < lim && n_a < target; i++) begin @(posedge clk); #2; end
    check_eq("reach_tick_sample", 32'(n_a >= target), 32'd1);
  endtask

  initial begin
    int hold_changes, done_before, q_before, img_before, bad;
    logic hold_tx;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    tick_en_a = 1'b1; ticks_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx_a", 32'(tx_a), 32'd1);
    check_eq("rst_busy_a", 32'(busy_a), 32'd0);
    check_eq("rst_txdone_a", 32'(txd_a), 32'd0);
    check_eq("rst_imgdone_a", 32'(img_a), 32'd0);
    check_eq("rst_addr_a", 32'(addr_a), 32'd0);
    check_eq("rst_tx_b", 32'(tx_b), 32'd1);
    check_eq("rst_busy_b", 32'(busy_b), 32'd0);
    check_eq("rst_addr_b", 32'(addr_b), 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0; ticks_b = 1'b1;

    // Single byte 0xA5
    pulse_start_a();
    @(negedge clk);
    check_eq("single_busy_high", 32'(busy_a), 32'd1);
    wait_img_a(2000, "single_img_done");
    check_eq("single_txdone_with_img", 32'(txd_a), 32'd1);
    @(negedge clk);
    check_eq("single_busy_low", 32'(busy_a), 32'd0);
    @(posedge clk); #2;
    check_eq("single_byte_count", 32'(q_a.size()), 32'd1);
    check_eq("single_byte", 32'(last_a()), 32'hA5);
    check_eq("single_slot_errors", 32'(slot_err_a), 32'd0);
    check_eq("single_done_align", 32'(align_err_a), 32'd0);
    check_eq("single_txdone_count", 32'(done_cnt_a), 32'd1);
    check_eq("single_img_count", 32'(img_cnt_a), 32'd1);
    check_eq("single_img_coincide", 32'(coinc_err_a), 32'd0);

    // Tick stall for 50 clk in the middle of data bit 1
    @(posedge clk); #1;
    pulse_start_a();
    wait_n_a(40, 1000);
    tick_en_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    hold_tx = tx_a;
    hold_changes = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_a !== hold_tx) hold_changes++;
    end
    check_eq("stall_tx_held", 32'(hold_changes), 32'd0);
    check_eq("stall_tx_is_bit1", 32'(hold_tx), 32'd0);
    @(posedge clk); #1;
    tick_en_a = 1'b1;
    wait_img_a(2000, "stall_img_done");
    @(posedge clk); #2;
    check_eq("stall_byte", 32'(last_a()), 32'hA5);
    check_eq("stall_slot_errors", 32'(slot_err_a), 32'd0);
    check_eq("stall_done_align", 32'(align_err_a), 32'd0);

    // Reset during data bit 3
    @(posedge clk); #1;
    pulse_start_a();
    wait_n_a(72, 1000);
    done_before = done_cnt_a; q_before = q_a.size(); img_before = img_cnt_a;
    rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("midrst_tx_high", 32'(tx_a), 32'd1);
    check_eq("midrst_busy_low", 32'(busy_a), 32'd0);
    check_eq("midrst_addr_zero", 32'(addr_a), 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (600) @(posedge clk);
    #2;
    check_eq("midrst_no_txdone", 32'(done_cnt_a), 32'(done_before));
    check_eq("midrst_no_imgdone", 32'(img_cnt_a), 32'(img_before));
    check_eq("midrst_no_byte", 32'(q_a.size()), 32'(q_before));
    check_eq("midrst_idle_tx", 32'(tx_a), 32'd1);
    @(posedge clk); #1;
    pulse_start_a();
    @(negedge clk);
    check_eq("restart_busy", 32'(busy_a), 32'd1);
    check_eq("restart_addr", 32'(addr_a), 32'd0);
    wait_img_a(2000, "restart_img_done");
    @(posedge clk); #2;
    check_eq("restart_byte", 32'(last_a()), 32'hA5);
    check_eq("restart_byte_count", 32'(q_a.size()), 32'(q_before + 1));

    // Full image on B, with a second start mid-image
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(negedge clk);
    check_eq("image_busy_high", 32'(busy_b), 32'd1);
    for (int i = 0; i < 10000 && q_b.size() < 300; i++) begin @(posedge clk); #2; end
    check_eq("image_reach_300", 32'(q_b.size() >= 300), 32'd1);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 30000 && img_b !== 1'b1; i++) @(negedge clk);
    check_eq("image_img_done", 32'(img_b), 32'd1);
    check_eq("image_last_addr", 32'(addr_b), 32'd783);
    check_eq("image_txdone_with_img", 32'(txd_b), 32'd1);

    // Back-to-back: start in the clk right after img_done
    @(posedge clk); #1;
    start_b = 1'b1;
    @(negedge clk);
    check_eq("image_busy_fell", 32'(busy_b), 32'd0);
    check_eq("image_addr_wrapped", 32'(addr_b), 32'd0);
    @(posedge clk); #1;
    start_b = 1'b0;
    @(negedge clk);
    check_eq("b2b_busy_high", 32'(busy_b), 32'd1);
    for (int i = 0; i < 500 && q_b.size() < 786; i++) begin @(posedge clk); #2; end
    bad = 0;
    for (int i = 0; i < 784; i++) if (qb_at(i) !== 8'(i)) bad++;
    check_eq("image_stream_errors", 32'(bad), 32'd0);
    check_eq("image_byte_783", 32'(qb_at(783)), 32'h0F);
    check_eq("image_img_count", 32'(img_cnt_b), 32'd1);
    check_eq("image_slot_errors", 32'(slot_err_b), 32'd0);
    check_eq("image_done_align", 32'(align_err_b), 32'd0);
    check_eq("image_img_coincide", 32'(coinc_err_b), 32'd0);
    check_eq("b2b_first_byte", 32'(qb_at(784)), 32'h00);
    check_eq("b2b_second_byte", 32'(qb_at(785)), 32'h01);

    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
